// File: rtl/apb_pkg.sv
// Shared types and default parameters for the APB4 memory slave.
package apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_WAIT   = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_st_e;

    // $clog2 that never returns 0, so derived vector widths stay legal.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and apb4_mem_slave.
// pstrb exists only when APB4_PSTRB_EN is defined.
interface apb4_mem_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB4_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
`ifdef APB4_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB4_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_sram.sv
// DEPTH x DATA_W storage: byte-enable write port, registered read port.
// Reset loads every word with its own index so the contents are known.
module apb_sram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic                rclr,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: index pattern on reset, byte-lane merge on write.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: holds its value until the next load or clear.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave with a fixed number of wait states per access.
// Optional macro APB4_PSTRB_EN adds pstrb byte-lane write strobes.
//
//   state  | meaning
//   IDLE   | waiting for a setup phase (psel=1, penable=0)
//   ACCESS | access phase; wcnt counts down, pready when wcnt==0
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WAIT   = DEF_WAIT
) (
    input logic             pclk,
    input logic             rst_n,
    apb4_mem_slave_if.slave bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int IDX_W   = clog2_min1(DEPTH);
    localparam int WCNT_W  = clog2_min1(WAIT + 1);

    apb_st_e           st_q, st_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              write_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;

    logic [ADDR_W-1:0] word_idx;
    logic              idx_err;
    logic              xfer_on;
    logic              capture;
    logic              mem_we;
    logic              rd_en;
    logic              rd_clr;
    logic [IDX_W-1:0]  rd_idx;
    logic [BYTES-1:0]  wr_be;
    logic              pready_int;

    assign word_idx = bus.paddr >> BYTE_SH;
    assign idx_err  = (word_idx >= ADDR_W'(DEPTH));
    assign xfer_on  = bus.psel & bus.penable;

    // Next-state, wait countdown and memory strobes.
    always_comb begin
        st_d    = st_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_clr  = 1'b0;
        case (st_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    st_d    = ACCESS;
                    wcnt_d  = WCNT_W'(WAIT);
                    capture = 1'b1;
                    // With no wait states the read must land on the setup edge.
                    if (WAIT == 0 && !bus.pwrite) begin
                        rd_clr = idx_err;
                        rd_en  = !idx_err;
                    end
                end
            end
            ACCESS: begin
                if (!xfer_on) begin
                    st_d   = IDLE;
                    wcnt_d = '0;
                end else if (wcnt_q == '0) begin
                    st_d   = IDLE;
                    mem_we = write_q && !err_q;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(1) && !write_q) begin
                        rd_clr = err_q;
                        rd_en  = !err_q;
                    end
                end
            end
            default: begin
                st_d   = IDLE;
                wcnt_d = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            wcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Setup-phase capture; the address phase is ignored once in ACCESS.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else if (capture) begin
            write_q <= bus.pwrite;
            err_q   <= idx_err;
            idx_q   <= word_idx[IDX_W-1:0];
        end
    end

    assign rd_idx = (st_q == IDLE) ? word_idx[IDX_W-1:0] : idx_q;

`ifdef APB4_PSTRB_EN
    assign wr_be = bus.pstrb;
`else
    assign wr_be = '1;
`endif

    assign pready_int  = (st_q == ACCESS) && (wcnt_q == '0);
    assign bus.pready  = pready_int;
    assign bus.pslverr = pready_int & err_q;

    apb_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .be     (wr_be),
        .waddr  (idx_q),
        .wdata  (bus.pwdata),
        .re     (rd_en),
        .rclr   (rd_clr),
        .raddr  (rd_idx),
        .rdata  (bus.prdata)
    );
endmodule
